// File: rtl/div_pkg.sv
// Shared types, default widths and helpers for the divider reconstruction
// checker.
package div_pkg;

  // Default widths: dividend/reconstruction, divisor, quotient, remainder.
  localparam int XW = 16;
  localparam int YW = 8;
  localparam int QW = 8;
  localparam int RW = 8;

  // Working width of abs_diff; callers zero-extend into it and truncate out.
  localparam int ABS_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIN
  } state_t;

  // Unsigned absolute difference |a - b|.
  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/div_reconstruct_seq_shift_add_acc.sv
// Shift-add multiplier datapath: acc accumulates q*y one quotient bit per
// step. Sequencing (how many steps, when to load) belongs to the caller.
module shift_add_acc
  import div_pkg::*;
#(
  parameter int XW = div_pkg::XW,
  parameter int YW = div_pkg::YW,
  parameter int QW = div_pkg::QW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [YW-1:0] y,
  input  logic [QW-1:0] q,
  output logic [XW:0]   acc
);

  // y_sh carries the shifted divisor; bits pushed past XW are dropped, which
  // is harmless because the caller guarantees XW >= QW + YW.
  logic [XW:0]   y_sh;
  logic [QW-1:0] q_sh;

  // Load operands or perform one conditional add-and-shift step.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // here samples the pre-edge values of the others (acc adds the old y_sh).
    if (rst) begin
      acc  <= '0;
      y_sh <= '0;
      q_sh <= '0;
    end else if (load) begin
      acc  <= '0;
      y_sh <= {{(XW + 1 - YW){1'b0}}, y};
      q_sh <= q;
    end else if (step) begin
      if (q_sh[0]) begin
        acc <= acc + y_sh;
      end
      y_sh <= y_sh << 1;
      q_sh <= q_sh >> 1;
    end
  end

endmodule

// File: rtl/div_reconstruct_seq.sv
// Sequential checker for divider results: rebuilds x_rec = q*y + r with a
// fixed-latency shift-add multiply and reports the absolute error against
// the original dividend, plus overflow / remainder-range / divide-by-zero
// flags.
module div_reconstruct_seq
  import div_pkg::*;
#(
  parameter int XW = div_pkg::XW,
  parameter int YW = div_pkg::YW,
  parameter int QW = div_pkg::QW,
  parameter int RW = div_pkg::RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x_in,
  input  logic [YW-1:0] y_in,
  input  logic [QW-1:0] q_in,
  input  logic [RW-1:0] r_in,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x_rec,
  output logic [XW-1:0] err_abs,
  output logic          exact,
  output logic          ovf,
  output logic          rem_bad,
  output logic          div0
);

  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam int EW = XW + 1;
  localparam int MW = (RW > YW) ? RW : YW;

  // The accumulator is XW+1 bits and discards shifted-out divisor bits, so
  // the full product must fit; abs_diff works at ABS_W bits.
  if (XW < QW + YW) begin : g_chk_prod
    $error("div_reconstruct_seq: XW (%0d) must be >= QW + YW (%0d)", XW, QW + YW);
  end
  if (RW > XW) begin : g_chk_rem
    $error("div_reconstruct_seq: RW (%0d) must be <= XW (%0d)", RW, XW);
  end
  if (EW > ABS_W) begin : g_chk_abs
    $error("div_reconstruct_seq: XW + 1 (%0d) exceeds abs_diff width %0d", EW, ABS_W);
  end

  state_t        state;
  state_t        state_nxt;
  logic          load;
  logic          step;
  logic          fin;
  logic [CW-1:0] cnt;

  logic [XW-1:0] x_l;
  logic [YW-1:0] y_l;
  logic [RW-1:0] r_l;

  logic [XW:0]   acc;
  logic [EW-1:0] sum;
  logic [EW-1:0] diff;
  logic [XW-1:0] err_sat;

  shift_add_acc #(
    .XW (XW),
    .YW (YW),
    .QW (QW)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .y    (y_in),
    .q    (q_in),
    .acc  (acc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath controls; MUL always runs QW steps so latency
  // does not depend on the quotient value.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path through
    // the case leaves one unassigned, which would infer a latch.
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL: begin
        step = 1'b1;
        if (cnt == CW'(QW - 1)) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration counter for the multiply phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Operand latch; start while busy never reaches here because load is only
  // raised in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_l <= '0;
      y_l <= '0;
      r_l <= '0;
    end else if (load) begin
      x_l <= x_in;
      y_l <= y_in;
      r_l <= r_in;
    end
  end

  // Final sum and saturated error distance, consumed in FIN.
  always_comb begin
    sum     = acc + {{(EW - RW){1'b0}}, r_l};
    diff    = EW'(abs_diff(ABS_W'(sum), ABS_W'(x_l)));
    err_sat = diff[XW] ? '1 : diff[XW-1:0];
  end

  // Result registers: updated with the done pulse, held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= 1'b0;
      x_rec   <= '0;
      err_abs <= '0;
      exact   <= 1'b0;
      ovf     <= 1'b0;
      rem_bad <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done <= fin;
      if (fin) begin
        x_rec   <= sum[XW-1:0];
        ovf     <= sum[XW];
        err_abs <= err_sat;
        exact   <= (diff == '0) && !sum[XW];
        rem_bad <= MW'(r_l) >= MW'(y_l);
        div0    <= (y_l == '0);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_div_reconstruct_seq.sv
// Self-checking bench for div_reconstruct_seq: directed cases, start
// collisions, mid-operation reset and random operands against an
// arithmetic reference model.
module tb_div_reconstruct_seq;

  localparam int XW  = 16;
  localparam int YW  = 8;
  localparam int QW  = 8;
  localparam int RW  = 8;
  localparam int LAT = QW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [XW-1:0] x_in;
  logic [YW-1:0] y_in;
  logic [QW-1:0] q_in;
  logic [RW-1:0] r_in;
  logic          busy;
  logic          done;
  logic [XW-1:0] x_rec;
  logic [XW-1:0] err_abs;
  logic          exact;
  logic          ovf;
  logic          rem_bad;
  logic          div0;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [XW-1:0] x_rec;
    logic [XW-1:0] err;
    logic          exact;
    logic          ovf;
    logic          rem_bad;
    logic          div0;
  } res_t;

  div_reconstruct_seq #(
    .XW (XW),
    .YW (YW),
    .QW (QW),
    .RW (RW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .x_in    (x_in),
    .y_in    (y_in),
    .q_in    (q_in),
    .r_in    (r_in),
    .busy    (busy),
    .done    (done),
    .x_rec   (x_rec),
    .err_abs (err_abs),
    .exact   (exact),
    .ovf     (ovf),
    .rem_bad (rem_bad),
    .div0    (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input int unsigned x, input int unsigned y,
                                 input int unsigned q, input int unsigned r);
    res_t   m;
    longint full;
    longint d;
    full = longint'(q) * longint'(y) + longint'(r);
    d    = full - longint'(x);
    if (d < 0) d = -d;
    m.x_rec   = XW'(full % (longint'(1) << XW));
    m.ovf     = full >= (longint'(1) << XW);
    m.err     = (d >= (longint'(1) << XW)) ? '1 : XW'(d);
    m.exact   = (d == 0) && !m.ovf;
    m.rem_bad = r >= y;
    m.div0    = (y == 0);
    return m;
  endfunction

  task automatic check_res(input string tag, input res_t e);
    check({tag, "_x_rec"},   x_rec,   e.x_rec);
    check({tag, "_err_abs"}, err_abs, e.err);
    check({tag, "_exact"},   exact,   e.exact);
    check({tag, "_ovf"},     ovf,     e.ovf);
    check({tag, "_rem_bad"}, rem_bad, e.rem_bad);
    check({tag, "_div0"},    div0,    e.div0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},    busy,    0);
    check({tag, "_done"},    done,    0);
    check({tag, "_x_rec"},   x_rec,   0);
    check({tag, "_err_abs"}, err_abs, 0);
    check({tag, "_exact"},   exact,   0);
    check({tag, "_ovf"},     ovf,     0);
    check({tag, "_rem_bad"}, rem_bad, 0);
    check({tag, "_div0"},    div0,    0);
  endtask

  // Present operands with start high, let one edge accept them, then return
  // 1 time unit after that accept edge.
  task automatic issue(input logic [XW-1:0] x, input logic [YW-1:0] y,
                       input logic [QW-1:0] q, input logic [RW-1:0] r);
    x_in  = x;
    y_in  = y;
    q_in  = q;
    r_in  = r;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // Count edges from the accept edge until done is seen, bounded.
  task automatic wait_done(input int lat_in, output int lat);
    lat = lat_in;
    while (lat < 4 * LAT) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic run(input string tag, input logic [XW-1:0] x, input logic [YW-1:0] y,
                     input logic [QW-1:0] q, input logic [RW-1:0] r);
    int   lat;
    res_t e;
    e = model(x, y, q, r);
    @(negedge clk);
    issue(x, y, q, r);
    wait_done(0, lat);
    check({tag, "_latency"}, lat, LAT);
    check_res(tag, e);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold"}, x_rec, e.x_rec);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int   lat;
    int   ndone;
    res_t ea;
    res_t ec;

    rst   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    q_in  = '0;
    r_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run("basic",    16'd8,   8'd4,   8'd2,   8'd0);
    run("exact199", 16'd199, 8'd7,   8'd28,  8'd3);
    run("approx",   16'd199, 8'd7,   8'd27,  8'd3);
    run("rembad",   16'd40,  8'd13,  8'd3,   8'd14);
    run("div0",     16'd5,   8'd0,   8'd255, 8'd5);
    run("corner",   16'd0,   8'd255, 8'd255, 8'd255);

    // Start while busy is ignored; start in the done cycle is accepted.
    ea = model(100, 9, 11, 1);
    @(negedge clk);
    issue(16'd100, 8'd9, 8'd11, 8'd1);
    repeat (2) @(posedge clk);
    #1;
    x_in  = 16'd7;
    y_in  = 8'd200;
    q_in  = 8'd200;
    r_in  = 8'd250;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3, lat);
    check("ignored_latency", lat, LAT);
    check_res("ignored", ea);
    ec = model(300, 10, 25, 30);
    issue(16'd300, 8'd10, 8'd25, 8'd30);
    wait_done(0, lat);
    check("b2b_latency", lat, LAT);
    check_res("b2b", ec);

    // Reset in the middle of MUL aborts and clears the held results.
    @(negedge clk);
    issue(16'd1234, 8'd50, 8'd20, 8'd60);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("midrst");
    ndone = 0;
    repeat (3 * LAT) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    repeat (2) @(negedge clk);
    run("after_rst", 16'd1234, 8'd50, 8'd20, 8'd34);

    // Random operands, mixing exact reconstructions with arbitrary dividends.
    for (int i = 0; i < 40; i++) begin
      logic [YW-1:0] y;
      logic [QW-1:0] q;
      logic [RW-1:0] r;
      logic [XW-1:0] x;
      y = YW'($urandom_range(0, 255));
      q = QW'($urandom_range(0, 255));
      r = RW'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) x = XW'(int'(q) * int'(y) + int'(r));
      else                           x = XW'($urandom_range(0, 65535));
      run("rand", x, y, q, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
